// File: rtl/ppp_token_sched_pkg.sv
// ppp_pkg: shared token type and constants for the packet-buffer token scheduler.
package ppp_pkg;
    localparam int NUM_BUF = 3;
    typedef logic [1:0] tok_t;
    localparam tok_t TOK_NONE = 2'd0;
    // Element 0 is the queue head, so the free queue comes out of reset as 1, 2, 3.
    localparam tok_t [NUM_BUF-1:0] FREE_INIT = {2'd3, 2'd2, 2'd1};
endpackage

// File: rtl/ppp_token_sched_tok_fifo.sv
// tok_fifo: depth-3 token queue with two prioritised enqueue ports and a loadable reset image.
module tok_fifo
    import ppp_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  tok_t [NUM_BUF-1:0]     init_mem,
    input  logic [1:0]             init_cnt,
    input  logic                   enq_a,
    input  tok_t                   din_a,
    input  logic                   enq_b,
    input  tok_t                   din_b,
    input  logic                   deq,
    output tok_t                   head,
    output logic [1:0]             count
);
    tok_t [NUM_BUF-1:0] mem, mem_nxt;
    logic [1:0] cnt_nxt;

    // Shift-register queue: the dequeue shifts first, then A and B append in that order.
    always_comb begin
        mem_nxt = mem;
        cnt_nxt = count;
        if (deq && count != 2'd0) begin
            mem_nxt = {TOK_NONE, mem[NUM_BUF-1:1]};
            cnt_nxt = count - 2'd1;
        end
        if (enq_a) begin
            mem_nxt[cnt_nxt] = din_a;
            cnt_nxt = cnt_nxt + 2'd1;
        end
        if (enq_b) begin
            mem_nxt[cnt_nxt] = din_b;
            cnt_nxt = cnt_nxt + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= init_mem;
            count <= init_cnt;
        end else begin
            mem   <= mem_nxt;
            count <= cnt_nxt;
        end
    end

    assign head = (count == 2'd0) ? TOK_NONE : mem[0];
endmodule

// File: rtl/ppp_token_sched.sv
// ppp_token_sched: circulates three buffer tokens free -> snooper -> CPU -> forwarder -> free.
module ppp_token_sched
    import ppp_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output tok_t             sn_token,
    input  logic             sn_done,
    output tok_t             cpu_token,
    input  logic             cpu_accept,
    input  logic             cpu_reject,
    output tok_t             fwd_token,
    input  logic             fwd_done,
    output logic [1:0]       free_cnt,
    output logic [1:0]       cpu_cnt,
    output logic [1:0]       fwd_cnt,
    output logic [CNT_W-1:0] acc_cnt,
    output logic [CNT_W-1:0] rej_cnt,
    output logic             err
);
    tok_t free_head, cpu_head, fwd_head;
    logic sn_rel, cpu_acc, cpu_rej, fwd_rel;
    logic sn_free, cpu_free, fwd_free, proto_err;

    // Releases only count when the agent actually holds a token; accept wins over reject.
    assign sn_rel   = sn_done && sn_token != TOK_NONE;
    assign cpu_acc  = cpu_accept && cpu_token != TOK_NONE;
    assign cpu_rej  = cpu_reject && !cpu_accept && cpu_token != TOK_NONE;
    assign fwd_rel  = fwd_done && fwd_token != TOK_NONE;
    assign sn_free  = sn_token == TOK_NONE || sn_rel;
    assign cpu_free = cpu_token == TOK_NONE || cpu_acc || cpu_rej;
    assign fwd_free = fwd_token == TOK_NONE || fwd_rel;
    assign proto_err = (sn_done && sn_token == TOK_NONE) ||
                       ((cpu_accept || cpu_reject) && cpu_token == TOK_NONE) ||
                       (cpu_accept && cpu_reject) ||
                       (fwd_done && fwd_token == TOK_NONE);

    tok_fifo u_free (
        .clk(clk), .rst_n(rst_n), .init_mem(FREE_INIT), .init_cnt(2'd3),
        .enq_a(cpu_rej), .din_a(cpu_token), .enq_b(fwd_rel), .din_b(fwd_token),
        .deq(sn_free), .head(free_head), .count(free_cnt)
    );

    tok_fifo u_cpu (
        .clk(clk), .rst_n(rst_n), .init_mem('0), .init_cnt(2'd0),
        .enq_a(sn_rel), .din_a(sn_token), .enq_b(1'b0), .din_b(TOK_NONE),
        .deq(cpu_free), .head(cpu_head), .count(cpu_cnt)
    );

    tok_fifo u_fwd (
        .clk(clk), .rst_n(rst_n), .init_mem('0), .init_cnt(2'd0),
        .enq_a(cpu_acc), .din_a(cpu_token), .enq_b(1'b0), .din_b(TOK_NONE),
        .deq(fwd_free), .head(fwd_head), .count(fwd_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sn_token  <= TOK_NONE;
            cpu_token <= TOK_NONE;
            fwd_token <= TOK_NONE;
            acc_cnt   <= '0;
            rej_cnt   <= '0;
            err       <= 1'b0;
        end else begin
            sn_token  <= sn_free ? free_head : sn_token;
            cpu_token <= cpu_free ? cpu_head : cpu_token;
            fwd_token <= fwd_free ? fwd_head : fwd_token;
            acc_cnt   <= acc_cnt + CNT_W'(cpu_acc);
            rej_cnt   <= rej_cnt + CNT_W'(cpu_rej);
            err       <= err || proto_err;
        end
    end
endmodule

// File: tb/tb_ppp_token_sched.sv
// tb_ppp_token_sched: directed token-circulation scenarios with hand-computed expectations.
module tb_ppp_token_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  sn_token, cpu_token, fwd_token;
    logic        sn_done = 1'b0, cpu_accept = 1'b0, cpu_reject = 1'b0, fwd_done = 1'b0;
    logic [1:0]  free_cnt, cpu_cnt, fwd_cnt;
    logic [31:0] acc_cnt, rej_cnt;
    logic        err;
    int          checks = 0;
    int          failures = 0;

    ppp_token_sched #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .sn_token(sn_token), .sn_done(sn_done),
        .cpu_token(cpu_token), .cpu_accept(cpu_accept), .cpu_reject(cpu_reject),
        .fwd_token(fwd_token), .fwd_done(fwd_done),
        .free_cnt(free_cnt), .cpu_cnt(cpu_cnt), .fwd_cnt(fwd_cnt),
        .acc_cnt(acc_cnt), .rej_cnt(rej_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock with the given releases held across the edge; outputs settle #1 later.
    task automatic cyc(input logic s, input logic a, input logic r, input logic f);
        sn_done = s; cpu_accept = a; cpu_reject = r; fwd_done = f;
        @(posedge clk);
        #1;
        sn_done = 1'b0; cpu_accept = 1'b0; cpu_reject = 1'b0; fwd_done = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_sn", sn_token, 0);
        chk("rst_free_cnt", free_cnt, 3);
        chk("rst_cpu_cnt", cpu_cnt, 0);
        chk("rst_err", err, 0);
        @(negedge clk) rst_n = 1'b1;
        cyc(0, 0, 0, 0);
        chk("c1_sn", sn_token, 1);
        chk("c1_free_cnt", free_cnt, 2);
        chk("c1_cpu", cpu_token, 0);
        chk("c1_fwd", fwd_token, 0);
        chk("c1_err", err, 0);
        cyc(1, 0, 0, 0);
        chk("c2_sn", sn_token, 2);
        chk("c2_cpu_cnt", cpu_cnt, 1);
        chk("c2_free_cnt", free_cnt, 1);
        chk("c2_cpu", cpu_token, 0);
        cyc(0, 0, 0, 0);
        chk("c3_cpu", cpu_token, 1);
        chk("c3_cpu_cnt", cpu_cnt, 0);
        cyc(1, 1, 0, 0);
        chk("c4_cpu", cpu_token, 0);
        chk("c4_sn", sn_token, 3);
        chk("c4_fwd_cnt", fwd_cnt, 1);
        chk("c4_cpu_cnt", cpu_cnt, 1);
        chk("c4_acc", acc_cnt, 1);
        chk("c4_free_cnt", free_cnt, 0);
        cyc(0, 0, 0, 0);
        chk("c5_cpu", cpu_token, 2);
        chk("c5_fwd", fwd_token, 1);
        chk("c5_fwd_cnt", fwd_cnt, 0);
        cyc(0, 0, 1, 1);
        chk("c6_free_cnt", free_cnt, 2);
        chk("c6_rej", rej_cnt, 1);
        chk("c6_acc", acc_cnt, 1);
        chk("c6_cpu", cpu_token, 0);
        chk("c6_fwd", fwd_token, 0);
        chk("c6_err", err, 0);
        cyc(1, 0, 0, 0);
        chk("c7_sn_first_free", sn_token, 2);
        chk("c7_free_cnt", free_cnt, 1);
        cyc(1, 0, 0, 0);
        chk("c8_sn_second_free", sn_token, 1);
        chk("c8_cpu", cpu_token, 3);
        chk("c8_cpu_cnt", cpu_cnt, 1);
        chk("c8_free_cnt", free_cnt, 0);
        // Asynchronous reset in the middle of a cycle.
        rst_n = 1'b0;
        #1;
        chk("arst_sn", sn_token, 0);
        chk("arst_cpu", cpu_token, 0);
        chk("arst_free_cnt", free_cnt, 3);
        chk("arst_cpu_cnt", cpu_cnt, 0);
        chk("arst_acc", acc_cnt, 0);
        chk("arst_rej", rej_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("p3_cpu", cpu_token, 1);
        chk("p3_sn", sn_token, 3);
        cyc(1, 0, 0, 0);
        chk("p4_sn", sn_token, 0);
        chk("p4_free_cnt", free_cnt, 0);
        chk("p4_cpu_cnt", cpu_cnt, 2);
        chk("p4_err", err, 0);
        cyc(0, 1, 1, 0);
        chk("p5_fwd_cnt", fwd_cnt, 1);
        chk("p5_cpu", cpu_token, 2);
        chk("p5_cpu_cnt", cpu_cnt, 1);
        chk("p5_acc", acc_cnt, 1);
        chk("p5_rej", rej_cnt, 0);
        chk("p5_err", err, 1);
        rst_n = 1'b0;
        #1;
        chk("arst2_err", err, 0);
        chk("arst2_fwd_cnt", fwd_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("q4_sn", sn_token, 0);
        chk("q4_err", err, 0);
        cyc(1, 0, 0, 0);
        chk("q5_err", err, 1);
        chk("q5_sn", sn_token, 0);
        chk("q5_cpu", cpu_token, 1);
        chk("q5_cpu_cnt", cpu_cnt, 2);
        chk("q5_free_cnt", free_cnt, 0);
        cyc(0, 0, 0, 0);
        chk("q6_err_sticky", err, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ppp_token_sched.md
Name: ppp_token_sched

Overview:
- Central scheduler for the three packet buffers (tokens 1, 2, 3; token 0 = "none") shared by the snooper, the CPU and the forwarder.
- Each agent holds at most one token at a time. Tokens circulate in a fixed loop: free -> snooper -> CPU -> forwarder -> free. A CPU reject sends the token straight from the CPU back to free.
- Three internal token queues (free, cpu, fwd) sit between the agents. The block guarantees exactly three tokens exist at all times.

Parameters:
- CNT_W, 32, width of the accept and reject statistics counters (wrap on overflow).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sn_token  out  2  token held by the snooper; 0 = none.
- sn_done  in  1  snooper finished writing its buffer; pulse.
- cpu_token  out  2  token held by the CPU; 0 = none.
- cpu_accept  in  1  CPU accepts its packet; token goes to the fwd queue.
- cpu_reject  in  1  CPU rejects its packet; token goes to the free queue.
- fwd_token  out  2  token held by the forwarder; 0 = none.
- fwd_done  in  1  forwarder finished sending; token goes to the free queue.
- free_cnt, cpu_cnt, fwd_cnt  out  2 each  current depth of each queue.
- acc_cnt, rej_cnt  out  CNT_W each  number of accepts / rejects.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async assert, any time including mid-operation):
  - free queue = {1, 2, 3}, head = 1; cpu and fwd queues empty.
  - sn_token, cpu_token, fwd_token = 0.
  - free_cnt = 3, cpu_cnt = 0, fwd_cnt = 0.
  - acc_cnt = 0, rej_cnt = 0, err = 0.
- Grant rule, per agent, each cycle:
  - An agent is free when its held token is 0, or it asserts its release input (done/accept/reject) this cycle.
  - If the agent is free and its source queue is non-empty: held <= head, and dequeue.
  - If the agent is free and its source queue is empty: held <= 0.
  - Source queues: snooper <- free, CPU <- cpu, forwarder <- fwd.
- Release routing, applied on the same edge as the grant:
  - sn_done: snooper's token enqueued on the cpu queue.
  - cpu_accept: CPU's token enqueued on the fwd queue; acc_cnt increments.
  - cpu_reject: CPU's token enqueued on the free queue; rej_cnt increments.
  - fwd_done: forwarder's token enqueued on the free queue.
- Latency:
  - A release in cycle N puts the token at the destination queue head in cycle N+1.
  - The next agent holds that token in cycle N+2 at the earliest.
  - A releasing agent can switch tokens without a gap if its source queue was non-empty in cycle N.
- Simultaneous enqueue: cpu_reject and fwd_done in the same cycle both enqueue on the free queue. The CPU token goes first (nearer the head), the forwarder token second.
- Enqueue to an empty queue and grant from it in the same cycle: not bypassed. The token becomes visible at the head next cycle.
- Protocol errors, each setting err = 1 (sticky until reset):
  - Release input asserted while that agent's token is 0: release ignored.
  - cpu_accept and cpu_reject asserted together: treated as accept only.
- Invariants:
  - Tokens held plus total queue depth = 3.
  - No token value appears twice.
  - Queues never overflow (depth 3 is sufficient); no overflow logic is required.
- Queue read of an empty queue returns head 0.

Decomposition:
- Shared package (ppp_pkg):
  - tok_t, a 2-bit token type.
  - TOK_NONE = 0.
  - NUM_BUF = 3.
  - Reset free order constants {1, 2, 3}.
- Sub-module tok_fifo, instantiated three times:
  - Depth-3 token FIFO with async active-low reset and a reset-contents input.
  - Two enqueue ports, A taking priority over B; one dequeue port.
  - Outputs: head (0 when empty) and count.

Test Plan:
- Reset release -> cycle 1: sn_token = 1, free_cnt = 2, cpu_token = 0, fwd_token = 0, err = 0.
- sn_done in cycle N -> N+1: sn_token = 2, cpu_cnt = 1. N+2: cpu_token = 1, cpu_cnt = 0.
- Full loop for token 1: snooper -> CPU accept -> forwarder fwd_done -> token 1 re-enters the free queue behind 3. acc_cnt = 1. The snooper sees token 1 again after tokens 2 and 3 are consumed.
- cpu_reject and fwd_done in the same cycle with CPU holding 2 and forwarder holding 1 (free queue empty) -> free queue order = 2 then 1, free_cnt = 2, rej_cnt = 1.
- All three tokens parked in the cpu queue (snooper issues sn_done three times, CPU never releases) -> sn_token = 0 and free_cnt = 0. A further sn_done sets err = 1; state is otherwise unchanged.
- cpu_accept and cpu_reject together -> routed to the fwd queue, acc_cnt +1, rej_cnt unchanged, err = 1. Asserting rst_n = 0 mid-stream then restores the reset state immediately (asynchronously).
